// File: rtl/fetch_stall_ctrl.sv
// Pipeline hazard controller: turns I/D-cache misses, load-use hazards and branch
// redirects into per-register stall/flush controls, and counts PC-stall cycles.
module fetch_stall_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Imiss,
  input  logic                 Dmiss,
  input  logic                 LoadUse,
  input  logic                 Mispredict,
  output logic                 PCStall,
  output logic                 IF_ID_Stall,
  output logic                 IF_ID_Flush,
  output logic                 ID_EX_Stall,
  output logic                 ID_EX_Flush,
  output logic                 EX_MEM_Stall,
  output logic                 FlushPipeandPC,
  output logic [1:0]           State,
  output logic [CNT_WIDTH-1:0] StallCnt
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_IMISS      = 2'd1,
    S_IMISS_KILL = 2'd2,
    S_DMISS      = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic flush_pc;
  } ctrl_t;

  state_e               state_q, state_d;
  logic                 redirect_pend_q, redirect_pend_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  ctrl_t  idle_ctrl, ctrl, ctrl_out;
  state_e idle_next;
  logic   idle_pend;

  // IDLE decision, also reused by IMISS on the cycle the instruction returns.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    idle_ctrl = '0;
    idle_next = S_IDLE;
    idle_pend = redirect_pend_q;
    if (Dmiss) begin
      idle_ctrl.pc_stall     = 1'b1;
      idle_ctrl.if_id_stall  = 1'b1;
      idle_ctrl.id_ex_stall  = 1'b1;
      idle_ctrl.ex_mem_stall = 1'b1;
      idle_pend              = redirect_pend_q | Mispredict;
      idle_next              = S_DMISS;
    end else if (Mispredict) begin
      idle_ctrl.flush_pc    = 1'b1;
      idle_ctrl.if_id_flush = 1'b1;
      idle_ctrl.id_ex_flush = 1'b1;
    end else if (LoadUse) begin
      idle_ctrl.pc_stall    = 1'b1;
      idle_ctrl.if_id_stall = 1'b1;
      idle_ctrl.id_ex_flush = 1'b1;
    end else if (Imiss) begin
      idle_ctrl.pc_stall    = 1'b1;
      idle_ctrl.if_id_flush = 1'b1;
      idle_next             = S_IMISS;
    end
  end

  always_comb begin
    ctrl            = '0;
    state_d         = state_q;
    redirect_pend_d = redirect_pend_q;
    unique case (state_q)
      S_IDLE: begin
        ctrl            = idle_ctrl;
        state_d         = idle_next;
        redirect_pend_d = idle_pend;
      end
      S_IMISS, S_IMISS_KILL: begin
        if (state_q == S_IMISS && !Imiss) begin
          ctrl            = idle_ctrl;
          state_d         = idle_next;
          redirect_pend_d = idle_pend;
        end else begin
          // Returned instruction in IMISS_KILL is wrong-path: drop it and redirect.
          ctrl.pc_stall    = Imiss;
          ctrl.if_id_flush = 1'b1;
          ctrl.flush_pc    = !Imiss;
          if (!Imiss) state_d = S_IDLE;
          if (Dmiss) begin
            ctrl.id_ex_stall  = 1'b1;
            ctrl.ex_mem_stall = 1'b1;
          end else if (state_q == S_IMISS && Mispredict) begin
            ctrl.id_ex_flush = 1'b1;
            state_d          = S_IMISS_KILL;
          end
        end
      end
      S_DMISS: begin
        if (Dmiss) begin
          ctrl.pc_stall     = 1'b1;
          ctrl.if_id_stall  = 1'b1;
          ctrl.id_ex_stall  = 1'b1;
          ctrl.ex_mem_stall = 1'b1;
          redirect_pend_d   = redirect_pend_q | Mispredict;
        end else begin
          ctrl.flush_pc    = redirect_pend_q;
          ctrl.if_id_flush = redirect_pend_q;
          ctrl.id_ex_flush = redirect_pend_q;
          redirect_pend_d  = 1'b0;
          state_d          = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ctrl_out = Rst ? '0 : ctrl;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ctrl_out.pc_stall && stall_cnt_q != {CNT_WIDTH{1'b1}})
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q         <= S_IDLE;
      redirect_pend_q <= 1'b0;
      stall_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      redirect_pend_q <= redirect_pend_d;
      stall_cnt_q     <= stall_cnt_d;
    end
  end

  assign PCStall        = ctrl_out.pc_stall;
  assign IF_ID_Stall    = ctrl_out.if_id_stall;
  assign IF_ID_Flush    = ctrl_out.if_id_flush;
  assign ID_EX_Stall    = ctrl_out.id_ex_stall;
  assign ID_EX_Flush    = ctrl_out.id_ex_flush;
  assign EX_MEM_Stall   = ctrl_out.ex_mem_stall;
  assign FlushPipeandPC = ctrl_out.flush_pc;
  assign State          = state_q;
  assign StallCnt       = stall_cnt_q;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed bench for fetch_stall_ctrl; output vector order is
// {PCStall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall, ID_EX_Flush, EX_MEM_Stall, FlushPipeandPC}.
module tb_fetch_stall_ctrl;

  localparam int CW = 3;  // small counter so saturation is reachable

  localparam logic [6:0] O_NONE  = 7'b000_0000;
  localparam logic [6:0] O_IMISS = 7'b101_0000;
  localparam logic [6:0] O_LU    = 7'b110_0100;
  localparam logic [6:0] O_FLUSH = 7'b001_0101;
  localparam logic [6:0] O_STALL = 7'b110_1010;
  localparam logic [6:0] O_KENT  = 7'b101_0100;
  localparam logic [6:0] O_KEXIT = 7'b001_0001;
  localparam logic [6:0] O_IMD   = 7'b101_1010;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          Imiss = 1'b0, Dmiss = 1'b0, LoadUse = 1'b0, Mispredict = 1'b0;
  logic          PCStall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall, ID_EX_Flush;
  logic          EX_MEM_Stall, FlushPipeandPC;
  logic [1:0]    State;
  logic [CW-1:0] StallCnt;
  logic [6:0]    outs;

  int checks = 0;
  int errors = 0;

  fetch_stall_ctrl #(.CNT_WIDTH(CW)) dut (
    .Clk(Clk), .Rst(Rst), .Imiss(Imiss), .Dmiss(Dmiss), .LoadUse(LoadUse),
    .Mispredict(Mispredict), .PCStall(PCStall), .IF_ID_Stall(IF_ID_Stall),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Stall(ID_EX_Stall), .ID_EX_Flush(ID_EX_Flush),
    .EX_MEM_Stall(EX_MEM_Stall), .FlushPipeandPC(FlushPipeandPC),
    .State(State), .StallCnt(StallCnt)
  );

  always #5 Clk = ~Clk;

  assign outs = {PCStall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall, ID_EX_Flush,
                 EX_MEM_Stall, FlushPipeandPC};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive {Imiss,Dmiss,LoadUse,Mispredict} at the falling edge, then check the
  // combinational outputs and the current state before the next rising edge.
  task automatic step(input string tag, input logic [3:0] in,
                      input logic [6:0] exp_o, input logic [1:0] exp_s);
    @(negedge Clk);
    {Imiss, Dmiss, LoadUse, Mispredict} = in;
    #1;
    check({tag, ".outs"}, 16'(outs), 16'(exp_o));
    check({tag, ".state"}, 16'(State), 16'(exp_s));
  endtask

  initial begin
    // Reset with all inputs asserted: outputs must stay quiet.
    {Imiss, Dmiss, LoadUse, Mispredict} = 4'b1111;
    #12;
    check("rst.outs", 16'(outs), 16'(O_NONE));
    check("rst.state", 16'(State), 16'd0);
    check("rst.cnt", 16'(StallCnt), 16'd0);
    @(negedge Clk);
    {Imiss, Dmiss, LoadUse, Mispredict} = 4'b0000;
    Rst = 1'b0;

    // Imiss for four cycles.
    step("im1", 4'b1000, O_IMISS, 2'd0);
    step("im2", 4'b1000, O_IMISS, 2'd1);
    step("im3", 4'b1000, O_IMISS, 2'd1);
    step("im4", 4'b1000, O_IMISS, 2'd1);
    step("im5", 4'b0000, O_NONE, 2'd1);
    step("im6", 4'b0000, O_NONE, 2'd0);
    check("im.cnt", 16'(StallCnt), 16'd4);

    // Single load-use hazard.
    step("lu1", 4'b0010, O_LU, 2'd0);
    step("lu2", 4'b0000, O_NONE, 2'd0);
    check("lu.cnt", 16'(StallCnt), 16'd5);

    // LoadUse + Imiss + Mispredict together: flush only.
    step("pri1", 4'b1011, O_FLUSH, 2'd0);
    step("pri2", 4'b0000, O_NONE, 2'd0);
    check("pri.cnt", 16'(StallCnt), 16'd5);

    // Imiss five cycles with a redirect in cycle 2; counter saturates at 7.
    step("ik1", 4'b1000, O_IMISS, 2'd0);
    step("ik2", 4'b1001, O_KENT, 2'd1);
    step("ik3", 4'b1000, O_IMISS, 2'd2);
    step("ik4", 4'b1000, O_IMISS, 2'd2);
    step("ik5", 4'b1000, O_IMISS, 2'd2);
    step("ik6", 4'b0000, O_KEXIT, 2'd2);
    step("ik7", 4'b0000, O_NONE, 2'd0);
    check("ik.cnt_sat", 16'(StallCnt), 16'd7);

    // Dmiss three cycles with a redirect in cycle 1.
    step("dm1", 4'b0101, O_STALL, 2'd0);
    step("dm2", 4'b0100, O_STALL, 2'd3);
    step("dm3", 4'b0100, O_STALL, 2'd3);
    step("dm4", 4'b0000, O_FLUSH, 2'd3);
    step("dm5", 4'b0000, O_NONE, 2'd0);
    check("dm.cnt_sat", 16'(StallCnt), 16'd7);

    // Dmiss during an I-miss gates Mispredict; the redirect is never taken.
    step("id1", 4'b1000, O_IMISS, 2'd0);
    step("id2", 4'b1101, O_IMD, 2'd1);
    step("id3", 4'b0100, O_STALL, 2'd1);
    step("id4", 4'b0000, O_NONE, 2'd3);
    step("id5", 4'b0000, O_NONE, 2'd0);

    // Asynchronous reset in DMISS with a pending redirect.
    step("ar1", 4'b0101, O_STALL, 2'd0);
    step("ar2", 4'b0100, O_STALL, 2'd3);
    #1;
    Rst = 1'b1;
    #1;
    check("ar.outs", 16'(outs), 16'(O_NONE));
    check("ar.state", 16'(State), 16'd0);
    check("ar.cnt", 16'(StallCnt), 16'd0);
    @(negedge Clk);
    {Imiss, Dmiss, LoadUse, Mispredict} = 4'b0000;
    Rst = 1'b0;
    step("ar3", 4'b0000, O_NONE, 2'd0);
    step("ar4", 4'b0000, O_NONE, 2'd0);
    check("ar.cnt_after", 16'(StallCnt), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
